// File: rtl/hex_dump_pkg.sv
// Shared types and character constants for the hex dump line formatter.
// The state enum keeps ADDR/SEP even when address output is compiled out.
package hex_dump_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_A     = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SEP,
        DATA,
        CR,
        LF
    } state_e;

endpackage

// File: rtl/hex_digit_encoder.sv
// Maps one nibble to its uppercase ASCII hex digit.
// Shared by the address and data fields of the formatter.
module hex_digit_encoder
    import hex_dump_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [7:0]          char_o
);

    always_comb begin
        if (nibble_i < 4'd10) begin
            char_o = CHAR_0 + {4'h0, nibble_i};
        end else begin
            char_o = CHAR_A + {4'h0, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_dump_formatter.sv
// Turns one address/data word into an ASCII hex line for a UART stream.
// Define HEX_DUMP_ADDRESS_EN to prefix each line with the address and a space.
module hex_dump_formatter
    import hex_dump_pkg::*;
#(
    parameter int address_width = 32,
    parameter int data_width    = 32,
    parameter int char_width    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [address_width-1:0] in_address,
    input  logic [data_width-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [char_width-1:0]    out_char,
    output logic                     busy
);

    localparam int AD = address_width / NIBBLE_W;
    localparam int DD = data_width / NIBBLE_W;
    localparam int AC = (AD > 1) ? $clog2(AD) : 1;
    localparam int DC = (DD > 1) ? $clog2(DD) : 1;
    localparam int CW = (AC > DC) ? AC : DC;

    localparam logic [CW-1:0] D_LAST = CW'(DD - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [data_width-1:0] data_q;
    logic                  capture;
    logic                  fire;
    logic [NIBBLE_W-1:0]   nib;
    logic [NIBBLE_W-1:0]   data_nib;
    logic [7:0]            digit_ch;
    logic [7:0]            out_c;

    assign fire      = out_valid & out_ready;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q != IDLE);

    // MSB-first: the selected nibble is shifted down to bit 0
    assign data_nib = NIBBLE_W'(data_q >> {D_LAST - cnt_q, 2'b00});

`ifdef HEX_DUMP_ADDRESS_EN
    localparam logic [CW-1:0] A_LAST = CW'(AD - 1);

    logic [address_width-1:0] addr_q;
    logic [NIBBLE_W-1:0]      addr_nib;

    assign addr_nib = NIBBLE_W'(addr_q >> {A_LAST - cnt_q, 2'b00});
    assign nib      = (state_q == ADDR) ? addr_nib : data_nib;

    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= in_address;
        end
    end
`else
    logic unused_addr;

    assign unused_addr = ^in_address;
    assign nib         = data_nib;
`endif

    always_ff @(posedge clk) begin
        if (capture) begin
            data_q <= in_data;
        end
    end

    hex_digit_encoder u_enc (
        .nibble_i (nib),
        .char_o   (digit_ch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
`ifdef HEX_DUMP_ADDRESS_EN
                    state_d = ADDR;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef HEX_DUMP_ADDRESS_EN
            ADDR: begin
                if (fire) begin
                    if (cnt_q == A_LAST) begin
                        state_d = SEP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEP: begin
                if (fire) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
`endif
            DATA: begin
                if (fire) begin
                    if (cnt_q == D_LAST) begin
                        state_d = CR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CR: begin
                if (fire) begin
                    state_d = LF;
                end
            end
            LF: begin
                if (fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Character is purely a function of state and counter, so it holds on stall
    always_comb begin
        out_c = 8'h00;
        unique case (state_q)
            ADDR:    out_c = digit_ch;
            DATA:    out_c = digit_ch;
            SEP:     out_c = CHAR_SPACE;
            CR:      out_c = CHAR_CR;
            LF:      out_c = CHAR_LF;
            default: out_c = 8'h00;
        endcase
    end

    assign out_char = char_width'(out_c);

endmodule

// File: tb/tb_hex_dump_formatter.sv
// Self-checking bench for hex_dump_formatter (32-bit and 16-bit data builds).
// Expectations follow HEX_DUMP_ADDRESS_EN when it is defined for the build.
module tb_hex_dump_formatter;

`ifdef HEX_DUMP_ADDRESS_EN
    localparam string PFX0     = "00000000 ";
    localparam string PFX10    = "00000010 ";
    localparam int    LINE_LEN = 19;
`else
    localparam string PFX0     = "";
    localparam string PFX10    = "";
    localparam int    LINE_LEN = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_address, in_data;
    logic [7:0]  out_char;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [31:0] in_address16;
    logic [15:0] in_data16;
    logic [7:0]  out_char16;

    always #5 clk = ~clk;

    hex_dump_formatter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_address (in_address),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .busy       (busy)
    );

    hex_dump_formatter #(.data_width(16)) dut16 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .in_address (in_address16),
        .in_data    (in_data16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .out_char   (out_char16),
        .busy       (busy16)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lf_cyc = 0;
    int b2b_done = 0;
    bit lf_seen = 0;
    bit chk_b2b = 0;
    bit stall_watch = 0;
    bit exp_valid_next = 0;
    byte unsigned exp_q[$];
    byte unsigned log_q[$];
    byte unsigned lit_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    function automatic byte unsigned hex_ch(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    // Reference model: the full line a word must produce
    task automatic model_line(input logic [31:0] a, input logic [31:0] d);
`ifdef HEX_DUMP_ADDRESS_EN
        for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ch(int'((a >> (4 * i)) & 32'hF)));
        exp_q.push_back(8'h20);
`else
        if (a === 32'hx) exp_q.push_back(8'h00);
`endif
        for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ch(int'((d >> (4 * i)) & 32'hF)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_valid_next) begin
                check("first_char_latency", {31'b0, out_valid}, 32'd1);
                exp_valid_next = 0;
            end
            if (in_valid && in_ready) begin
                if (chk_b2b && lf_seen) begin
                    check("b2b_accept_gap", cyc - lf_cyc, 32'd1);
                    b2b_done++;
                end
                acc_cyc = cyc;
                lf_seen = 0;
                model_line(in_address, in_data);
                exp_valid_next = 1;
            end
            if (out_valid) begin
                check("ready_busy_in_line", {30'b0, in_ready, busy}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", {24'b0, out_char}, 32'hFFFF_FFFF);
                end else begin
                    byte unsigned e;
                    e = exp_q.pop_front();
                    check("char", {24'b0, out_char}, {24'b0, e});
                    log_q.push_back(out_char);
                    if (e == 8'h0A) begin
                        lf_cyc  = cyc;
                        lf_seen = 1;
                    end
                end
            end else if (!out_ready && stall_watch) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                if (exp_q.size() > 0) begin
                    check("stall_hold", {24'b0, out_char}, {24'b0, exp_q[0]});
                end
            end
        end
    end

    task automatic lit_line(input string s);
        for (int i = 0; i < s.len(); i++) lit_q.push_back(s[i]);
        lit_q.push_back(8'h0D);
        lit_q.push_back(8'h0A);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, log_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size(); i++) begin
            if (i < log_q.size()) begin
                check(name, {24'b0, log_q[i]}, {24'b0, lit_q[i]});
            end
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        lit_q.delete();
    endtask

    // Holds in_valid until the word is taken; returns at posedge+1 after accept
    task automatic accept_wait(input string name);
        int  n;
        bit  ok;
        n = 0;
        do begin
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        in_address = a;
        in_data    = d;
        in_valid   = 1'b1;
        accept_wait("send");
        in_valid   = 1'b0;
        in_address = 32'h5A5A_5A5A;
        in_data    = 32'hA5A5_A5A5;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        byte unsigned e16[$];

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_address   = '0;
        in_data      = '0;
        out_ready    = 1'b1;
        in_valid16   = 1'b0;
        in_address16 = '0;
        in_data16    = '0;
        out_ready16  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_char", {24'b0, out_char}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic line, full rate
        clear_logs();
        lit_line({PFX0, "1234ABCD"});
        send(32'h0, 32'h1234_ABCD);
        wait_idle("t1");
        check_log("t1_line");
        check("t1_span", lf_cyc - acc_cyc, LINE_LEN);
        check("t1_idle_char", {24'b0, out_char}, 32'd0);

        // Back-pressure while '2' is presented
        clear_logs();
        lit_line({PFX0, "1234ABCD"});
        send(32'h0, 32'h1234_ABCD);
        n = 0;
        while (!(out_valid && out_char == 8'h32) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t2_found_2", {24'b0, out_char}, 32'h32);
        stall_watch = 1;
        out_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t2_stall_char", {24'b0, out_char}, 32'h32);
            check("t2_stall_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready   = 1'b1;
        stall_watch = 0;
        wait_idle("t2");
        check_log("t2_line");
        check("t2_span", lf_cyc - acc_cyc, LINE_LEN + 3);

        // Address field and separator
        clear_logs();
        lit_line({PFX10, "DEADBEEF"});
        send(32'h0000_0010, 32'hDEAD_BEEF);
        wait_idle("t3");
        check_log("t3_line");
        check("t3_span", lf_cyc - acc_cyc, LINE_LEN);

        // in_valid held across two words
        clear_logs();
        lit_line({PFX0, "00000001"});
        lit_line({PFX0, "FFFFFFFF"});
        lf_seen    = 0;
        chk_b2b    = 1;
        b2b_done   = 0;
        in_address = 32'h0;
        in_data    = 32'h0000_0001;
        in_valid   = 1'b1;
        accept_wait("t4a");
        in_data    = 32'hFFFF_FFFF;
        accept_wait("t4b");
        in_valid   = 1'b0;
        wait_idle("t4");
        chk_b2b    = 0;
        check_log("t4_lines");
        check("t4_b2b_seen", b2b_done, 32'd1);

        // Reset in the middle of a line
        clear_logs();
        send(32'h0, 32'h1234_ABCD);
        n = 0;
        while (log_q.size() < PFX0.len() + 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_pre_count", log_q.size(), PFX0.len() + 4);
        if (log_q.size() >= PFX0.len() + 4) begin
            check("t5_4th_char", {24'b0, log_q[PFX0.len() + 3]}, 32'h34);
        end
        reset = 1'b1;
        #1;
        check("t5_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5_in_ready", {31'b0, in_ready}, 32'd1);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_out_char", {24'b0, out_char}, 32'd0);
        exp_q.delete();
        exp_valid_next = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        lit_line({PFX0, "0F1E2D3C"});
        @(posedge clk);
        #1;
        send(32'h0, 32'h0F1E_2D3C);
        wait_idle("t5");
        check_log("t5_line");

        // 16-bit data build
        for (int i = 0; i < PFX0.len(); i++) e16.push_back(PFX0[i]);
        e16.push_back(8'h30);
        e16.push_back(8'h30);
        e16.push_back(8'h41);
        e16.push_back(8'h35);
        e16.push_back(8'h0D);
        e16.push_back(8'h0A);
        in_data16  = 16'h00A5;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        in_data16  = 16'hFFFF;
        for (int i = 0; i < e16.size(); i++) begin
            check("t6_valid", {31'b0, out_valid16}, 32'd1);
            check("t6_char", {24'b0, out_char16}, {24'b0, e16[i]});
            @(posedge clk);
            #1;
        end
        check("t6_idle", {31'b0, in_ready16}, 32'd1);

        check("exp_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_dump_formatter.md
HEX_DUMP_FORMATTER -- requirements
Module: hex_dump_formatter

Interface
REQ-001 The block SHALL have parameter address_width, default 32, address word width in bits (multiple of 4).
REQ-002 The block SHALL have parameter data_width, default 32, data word width in bits (multiple of 4).
REQ-003 The block SHALL have parameter char_width, default 8, output character width in bits.
REQ-004 The block SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid  input  1  word offered.
REQ-007 The block SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-008 The block SHALL have port in_address  input  address_width  address of the offered word.
REQ-009 The block SHALL have port in_data  input  data_width  data of the offered word.
REQ-010 The block SHALL have port out_valid  output  1  out_char is valid.
REQ-011 The block SHALL have port out_ready  input  1  downstream (UART TX) takes the character when out_valid & out_ready.
REQ-012 The block SHALL have port out_char  output  char_width  ASCII character.
REQ-013 The block SHALL have port busy  output  1  a line is in progress.

Function
REQ-014 The block SHALL capture in_address and in_data into internal registers on the accepting handshake; later input changes do not affect the line.
REQ-015 in_ready SHALL equal (state == IDLE), so there is one bubble cycle between lines.
REQ-016 The FSM SHALL have states IDLE, ADDR, SEP, DATA, CR, LF.
REQ-017 Transitions SHALL be IDLE->ADDR on accept if HEX_DUMP_ADDRESS_EN, else IDLE->DATA; ADDR->SEP after the last address digit handshake; SEP->DATA on handshake; DATA->CR after the last data digit handshake; CR->LF on handshake; LF->IDLE on handshake.
REQ-018 out_valid SHALL be 1 in every state except IDLE, with the first character valid on the cycle after accept.
REQ-019 A state, digit counter or out_char SHALL advance only on out_valid & out_ready; while out_ready=0, out_char SHALL hold stable.
REQ-020 Digits SHALL be emitted most-significant nibble first, as 0-9 -> 0x30-0x39 and 10-15 -> 0x41-0x46 (uppercase).
REQ-021 SEP SHALL emit 0x20, CR SHALL emit 0x0D, and LF SHALL emit 0x0A.
REQ-022 The digit counter SHALL be $clog2(width/4) bits wide, reset to 0 on entry to ADDR or DATA, and end the field at width/4-1 with no wrap beyond.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 out_char SHALL read 0 in IDLE.

Reset
REQ-025 On reset (asynchronous), state SHALL go to IDLE, the counter to 0, out_valid to 0, busy to 0, in_ready to 1 and out_char to 0.
REQ-026 Reset asserted mid-line SHALL abandon the partial line with no CR/LF emitted; the captured word registers need no reset.

Configuration
REQ-027 Macro HEX_DUMP_ADDRESS_EN defined SHALL give each line address_width/4 address digits, one space, data_width/4 data digits, CR, LF.
REQ-028 Macro HEX_DUMP_ADDRESS_EN undefined SHALL give each line data digits, CR, LF only; ADDR/SEP are unreachable, the address register is removed, and in_address is ignored.

Structure
REQ-029 Package hex_dump_pkg SHALL hold the state enum, the CHAR_SPACE/CHAR_CR/CHAR_LF/CHAR_0/CHAR_A constants and the nibble width constant.
REQ-030 A combinational sub-module hex_digit_encoder SHALL map a 4-bit nibble to an ASCII char, shared by the ADDR and DATA paths.

Verification
REQ-031 With no macro, in_data=32'h1234ABCD and out_ready=1, the bench SHALL check out_char = 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles starting 1 cycle after accept, then in_ready=1.
REQ-032 With the same word and out_ready=0 for 3 cycles while '2' (0x32) is presented, the bench SHALL check out_char stays 0x32 and out_valid=1 throughout, and the sequence resumes with no loss or duplication.
REQ-033 With HEX_DUMP_ADDRESS_EN, in_address=32'h00000010 and in_data=32'hDEADBEEF, the bench SHALL check the stream "00000010 DEADBEEF" then 0D 0A, 19 chars in total.
REQ-034 With in_valid held 1 over two words 32'h00000001 then 32'hFFFFFFFF, the bench SHALL check in_ready=0 during line 1, the second accept falls exactly 1 cycle after the LF handshake, and line 2 reads "FFFFFFFF".
REQ-035 With reset pulsed after the 4th data char, the bench SHALL check out_valid=0 and in_ready=1 immediately, and the next word gives a complete line from its first digit.
REQ-036 With data_width=16 and in_data=16'h00A5, the bench SHALL check the stream 30 30 41 35 0D 0A.
